// File: rtl/fpu_cmp_issue_if.sv
// Signal bundle between FPU dispatch, the FP compare unit and integer writeback.
// The slave modport is the sequencing stage; the master modport is its environment.
interface fpu_cmp_issue_if;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [4:0]  req_rd;
   logic [31:0] cmp_a;
   logic [31:0] cmp_b;
   logic        cmp_is_eq;
   logic        cmp_is_le;
   logic [31:0] cmp_q;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [4:0]  rsp_rd;
   logic        rsp_err;
   logic        rsp_invalid;
   logic        busy;

   modport slave (
      input  req_valid, req_op, req_a, req_b, req_rd, cmp_q, rsp_ready,
      output req_ready, cmp_a, cmp_b, cmp_is_eq, cmp_is_le,
             rsp_valid, rsp_data, rsp_rd, rsp_err, rsp_invalid, busy
   );

   modport master (
      output req_valid, req_op, req_a, req_b, req_rd, cmp_q, rsp_ready,
      input  req_ready, cmp_a, cmp_b, cmp_is_eq, cmp_is_le,
             rsp_valid, rsp_data, rsp_rd, rsp_err, rsp_invalid, busy
   );
endinterface

// File: rtl/fpu_cmp_issue.sv
// Sequencing stage around the fixed-latency FP compare unit: one feq/flt/fle in flight.
// Optional NaN detection (forces unordered result, raises rsp_invalid) under `FPU_CMP_NAN_EN.
module fpu_cmp_issue #(
   parameter int unsigned LATENCY = 1
) (
   input  logic           clk,
   input  logic           rstn,
   fpu_cmp_issue_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic [3:0] LAT_INIT = 4'(LATENCY);
   localparam logic [1:0] OP_LE    = 2'b01;
   localparam logic [1:0] OP_EQ    = 2'b10;
   localparam logic [1:0] OP_RSVD  = 2'b11;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] cmp_a_q, cmp_a_d;
   logic [31:0] cmp_b_q, cmp_b_d;
   logic        is_eq_q, is_eq_d;
   logic        is_le_q, is_le_d;
   logic [4:0]  rd_q, rd_d;
   logic        rsvd_q, rsvd_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_bit_q, rsp_bit_d;
   logic [4:0]  rsp_rd_q, rsp_rd_d;
   logic        rsp_err_q, rsp_err_d;
`ifdef FPU_CMP_NAN_EN
   logic        nan_q, nan_d;
   logic        rsp_inv_q, rsp_inv_d;
`endif

   logic req_ready;
   logic accept;
   logic unused_cmp_hi;

`ifdef FPU_CMP_NAN_EN
   function automatic logic is_nan(input logic [31:0] f);
      return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
   endfunction
`endif

   // A response being drained in the same cycle frees the slot for the next request.
   assign req_ready = (state_q == IDLE) | ((state_q == RESP) & bus.rsp_ready);
   assign accept    = bus.req_valid & req_ready;

   // The compare unit only drives bit 0 with meaning.
   assign unused_cmp_hi = ^bus.cmp_q[31:1];

   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
      state_d     = state_q;
      cnt_d       = cnt_q;
      cmp_a_d     = cmp_a_q;
      cmp_b_d     = cmp_b_q;
      is_eq_d     = is_eq_q;
      is_le_d     = is_le_q;
      rd_d        = rd_q;
      rsvd_d      = rsvd_q;
      rsp_valid_d = rsp_valid_q;
      rsp_bit_d   = rsp_bit_q;
      rsp_rd_d    = rsp_rd_q;
      rsp_err_d   = rsp_err_q;
`ifdef FPU_CMP_NAN_EN
      nan_d       = nan_q;
      rsp_inv_d   = rsp_inv_q;
`endif

      unique case (state_q)
         IDLE: ;
         WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
`ifdef FPU_CMP_NAN_EN
               rsp_bit_d = bus.cmp_q[0] & ~rsvd_q & ~nan_q;
               rsp_inv_d = nan_q;
`else
               rsp_bit_d = bus.cmp_q[0] & ~rsvd_q;
`endif
               rsp_err_d   = rsvd_q;
               rsp_rd_d    = rd_q;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Accept overrides the RESP->IDLE exit so back-to-back requests see no bubble.
      if (accept) begin
         cmp_a_d = bus.req_a;
         cmp_b_d = bus.req_b;
         is_eq_d = (bus.req_op == OP_EQ);
         is_le_d = (bus.req_op == OP_LE);
         rd_d    = bus.req_rd;
         rsvd_d  = (bus.req_op == OP_RSVD);
`ifdef FPU_CMP_NAN_EN
         nan_d   = is_nan(bus.req_a) | is_nan(bus.req_b);
`endif
         cnt_d   = LAT_INIT;
         state_d = WAIT;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         cmp_a_q     <= 32'd0;
         cmp_b_q     <= 32'd0;
         is_eq_q     <= 1'b0;
         is_le_q     <= 1'b0;
         rd_q        <= 5'd0;
         rsvd_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_bit_q   <= 1'b0;
         rsp_rd_q    <= 5'd0;
         rsp_err_q   <= 1'b0;
`ifdef FPU_CMP_NAN_EN
         nan_q       <= 1'b0;
         rsp_inv_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cmp_a_q     <= cmp_a_d;
         cmp_b_q     <= cmp_b_d;
         is_eq_q     <= is_eq_d;
         is_le_q     <= is_le_d;
         rd_q        <= rd_d;
         rsvd_q      <= rsvd_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_bit_q   <= rsp_bit_d;
         rsp_rd_q    <= rsp_rd_d;
         rsp_err_q   <= rsp_err_d;
`ifdef FPU_CMP_NAN_EN
         nan_q       <= nan_d;
         rsp_inv_q   <= rsp_inv_d;
`endif
      end
   end

   assign bus.req_ready   = req_ready;
   assign bus.cmp_a       = cmp_a_q;
   assign bus.cmp_b       = cmp_b_q;
   assign bus.cmp_is_eq   = is_eq_q;
   assign bus.cmp_is_le   = is_le_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_data    = {31'd0, rsp_bit_q};
   assign bus.rsp_rd      = rsp_rd_q;
   assign bus.rsp_err     = rsp_err_q;
`ifdef FPU_CMP_NAN_EN
   assign bus.rsp_invalid = rsp_inv_q;
`else
   assign bus.rsp_invalid = 1'b0;
`endif
   assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_cmp_issue.sv
// Bench for fpu_cmp_issue: directed scenarios then randomized requests, checked
// against a float-ordering reference model; also models the compare unit pipeline.
module tb_fpu_cmp_issue;

   localparam int unsigned LAT = 1;
`ifdef FPU_CMP_NAN_EN
   localparam bit NAN_EN = 1'b1;
`else
   localparam bit NAN_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   fpu_cmp_issue_if bus ();

   fpu_cmp_issue #(.LATENCY(LAT)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int tests = 0;
   int fails = 0;
   logic [31:0] last_data;
   logic [4:0]  last_rd;
   logic        last_err;
   logic        last_inv;

   function automatic logic is_nan(input logic [31:0] f);
      return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
   endfunction

   // Map a float onto an unsigned key whose integer order is the numeric order.
   function automatic logic [31:0] order_key(input logic [31:0] f);
      return f[31] ? ~f : (f | 32'h8000_0000);
   endfunction

   function automatic logic fcmp(input logic [31:0] a, input logic [31:0] b,
                                 input logic eq, input logic le);
      logic both_zero, lt, e;
      both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
      e  = both_zero || (a == b);
      lt = !both_zero && (order_key(a) < order_key(b));
      if (eq) return e;
      if (le) return lt | e;
      return lt;
   endfunction

   function automatic logic exp_bit(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op == 2'b11) return 1'b0;
      if (NAN_EN && (is_nan(a) || is_nan(b))) return 1'b0;
      return fcmp(a, b, op == 2'b10, op == 2'b01);
   endfunction

   function automatic logic [31:0] rand_fp();
      logic [31:0] r;
      r = $urandom();
      case ($urandom_range(0, 5))
         0: return r;
         1: return 32'h0000_0000;
         2: return 32'h8000_0000;
         3: return {r[31], 8'hFF, 23'($urandom_range(1, 32'h7F_FFFF))};
         4: return {r[31], 8'hFF, 23'd0};
         default: return {r[31], 8'h7F, r[22:0]};
      endcase
   endfunction

   // Compare unit model: result pipelined LAT edges, upper bits are junk.
   logic [31:0] pipe [LAT];
   always @(posedge clk) begin
      pipe[0] <= {31'($urandom()), fcmp(bus.cmp_a, bus.cmp_b, bus.cmp_is_eq, bus.cmp_is_le)};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign bus.cmp_q = pipe[LAT-1];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.req_rd    = rd;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmp_a"}, bus.cmp_a, 32'd0);
      check({tag, "_cmp_b"}, bus.cmp_b, 32'd0);
      check({tag, "_is_eq"}, 32'(bus.cmp_is_eq), 32'd0);
      check({tag, "_is_le"}, 32'(bus.cmp_is_le), 32'd0);
      check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      check({tag, "_rsp_data"}, bus.rsp_data, 32'd0);
      check({tag, "_rsp_rd"}, 32'(bus.rsp_rd), 32'd0);
      check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
      check({tag, "_rsp_invalid"}, 32'(bus.rsp_invalid), 32'd0);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
   endtask

   // Called just after the accept edge: watch WAIT, then check the response.
   task automatic wait_rsp(input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd);
      int lat;
      #1;
      lat = 0;
      while (!bus.rsp_valid && lat < 40) begin
         check("wait_cmp_a", bus.cmp_a, a);
         check("wait_cmp_b", bus.cmp_b, b);
         check("wait_is_eq", 32'(bus.cmp_is_eq), 32'(op == 2'b10));
         check("wait_is_le", 32'(bus.cmp_is_le), 32'(op == 2'b01));
         check("wait_busy", 32'(bus.busy), 32'd1);
         check("wait_req_ready", 32'(bus.req_ready), 32'd0);
         tick();
         lat++;
      end
      check("latency", 32'(lat), 32'(LAT + 1));
      last_data = {31'd0, exp_bit(op, a, b)};
      last_rd   = rd;
      last_err  = (op == 2'b11);
      last_inv  = NAN_EN && (is_nan(a) || is_nan(b));
      check("rsp_data", bus.rsp_data, last_data);
      check("rsp_rd", 32'(bus.rsp_rd), 32'(last_rd));
      check("rsp_err", 32'(bus.rsp_err), 32'(last_err));
      check("rsp_invalid", 32'(bus.rsp_invalid), 32'(last_inv));
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
      drive_req(op, a, b, rd);
      #1;
      check("issue_req_ready", 32'(bus.req_ready), 32'd1);
      tick();
      bus.req_valid = 1'b0;
      bus.req_op    = 2'($urandom());
      bus.req_a     = $urandom();
      wait_rsp(op, a, b, rd);
   endtask

   task automatic handoff(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
      drive_req(op, a, b, rd);
      bus.rsp_ready = 1'b1;
      #1;
      check("b2b_req_ready", 32'(bus.req_ready), 32'd1);
      tick();
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b0;
      check("b2b_rsp_dropped", 32'(bus.rsp_valid), 32'd0);
      check("b2b_busy", 32'(bus.busy), 32'd1);
      wait_rsp(op, a, b, rd);
   endtask

   task automatic hold(input int n);
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < n; i++) begin
         tick();
         check("hold_valid", 32'(bus.rsp_valid), 32'd1);
         check("hold_data", bus.rsp_data, last_data);
         check("hold_rd", 32'(bus.rsp_rd), 32'(last_rd));
         check("hold_err", 32'(bus.rsp_err), 32'(last_err));
         check("hold_req_ready", 32'(bus.req_ready), 32'd0);
      end
   endtask

   task automatic release_rsp();
      bus.rsp_ready = 1'b1;
      #1;
      check("rel_req_ready", 32'(bus.req_ready), 32'd1);
      tick();
      bus.rsp_ready = 1'b0;
      check("rel_valid", 32'(bus.rsp_valid), 32'd0);
      check("rel_busy", 32'(bus.busy), 32'd0);
      check("rel_data_kept", bus.rsp_data, last_data);
      check("rel_rd_kept", 32'(bus.rsp_rd), 32'(last_rd));
   endtask

   initial begin
      logic [1:0]  op;
      logic [31:0] a, b;
      logic [4:0]  rd;

      rstn          = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_op    = 2'b00;
      bus.req_a     = 32'd0;
      bus.req_b     = 32'd0;
      bus.req_rd    = 5'd0;
      bus.rsp_ready = 1'b0;
      tick();
      check_reset_outputs("reset");
      tick();
      rstn = 1'b1;
      tick();

      // flt 1.0 < 2.0
      issue(2'b00, 32'h3F80_0000, 32'h4000_0000, 5'd5);
      release_rsp();
      // fle pi <= pi
      issue(2'b01, 32'h4049_0FDB, 32'h4049_0FDB, 5'd7);
      release_rsp();
      // feq 1.0 == 2.0, then backpressure and same-edge handoff
      issue(2'b10, 32'h3F80_0000, 32'h4000_0000, 5'd12);
      hold(5);
      handoff(2'b00, 32'h4000_0000, 32'h3F80_0000, 5'd9);
      release_rsp();
      // reserved op
      issue(2'b11, $urandom(), $urandom(), 5'd3);
      release_rsp();
      // NaN operand
      issue(2'b01, 32'h7FC0_0000, 32'h3F80_0000, 5'd4);
      release_rsp();

      // Reset while in WAIT drops the request.
      drive_req(2'b00, 32'h3F80_0000, 32'h4000_0000, 5'd21);
      tick();
      bus.req_valid = 1'b0;
      tick();
      rstn = 1'b0;
      #1;
      check_reset_outputs("rst_wait");
      tick();
      rstn = 1'b1;
      for (int i = 0; i < int'(LAT) + 4; i++) begin
         tick();
         check("post_rst_valid", 32'(bus.rsp_valid), 32'd0);
         check("post_rst_busy", 32'(bus.busy), 32'd0);
         check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
      end

      // Randomized traffic with random backpressure and back-to-back handoffs.
      for (int i = 0; i < 30; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = rand_fp();
         b  = ($urandom_range(0, 3) == 0) ? a : rand_fp();
         rd = 5'($urandom());
         if (i > 0 && $urandom_range(0, 1) == 1) begin
            handoff(op, a, b, rd);
         end else begin
            if (i > 0) release_rsp();
            issue(op, a, b, rd);
         end
         hold($urandom_range(0, 3));
      end
      release_rsp();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fpu_cmp_issue.md
Name: fpu_cmp_issue

Overview:
- Sequencing stage wrapped around the FP compare unit.
- Accepts decoded FP compare requests (feq/flt/fle) from the FPU dispatch path over a valid/ready handshake.
- Registers operands and mode bits onto the compare unit's inputs, waits out the unit's fixed pipeline latency, then captures the 32-bit 0/1 result.
- Returns the result with its destination register tag to integer writeback over a second valid/ready handshake. One request in flight at a time.

Parameters:
- LATENCY, 1, clock edges from compare inputs stable to compare result valid; legal range 0..15.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rstn  input  1  reset, asynchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request this cycle
- req_op  input  2  00 = lt, 01 = le, 10 = eq, 11 = reserved
- req_a  input  32  operand a, IEEE-754 single
- req_b  input  32  operand b, IEEE-754 single
- req_rd  input  5  destination register tag
- cmp_a  output  32  operand a to the compare unit
- cmp_b  output  32  operand b to the compare unit
- cmp_is_eq  output  1  selects the equality result
- cmp_is_le  output  1  selects the less-or-equal result
- cmp_q  input  32  compare unit result; only bit 0 is meaningful
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts the response
- rsp_data  output  32  {31'b0, result}
- rsp_rd  output  5  echoed destination tag
- rsp_err  output  1  reserved op was issued
- rsp_invalid  output  1  NaN operand seen (see Optional Feature)
- busy  output  1  state != IDLE

Behaviour:
- State machine: IDLE, WAIT, RESP. State register, counter and all registered outputs reset asynchronously on rstn low.
- Reset values:
  - state = IDLE; counter = 0.
  - cmp_a = cmp_b = 0; cmp_is_eq = cmp_is_le = 0.
  - rsp_valid = 0; rsp_data = 0; rsp_rd = 0; rsp_err = 0; rsp_invalid = 0; busy = 0.
- req_ready is combinational: (state == IDLE) | (state == RESP & rsp_ready). It therefore reads 1 during and immediately after reset.
- Accept = req_valid & req_ready. On the accept edge:
  - load cmp_a/cmp_b from req_a/req_b;
  - load cmp_is_eq = (op == 10), cmp_is_le = (op == 01); lt and reserved give 0/0;
  - latch req_rd and the reserved-op flag;
  - load counter = LATENCY; go to WAIT.
- WAIT:
  - counter != 0: decrement.
  - counter == 0: capture rsp_data = {31'b0, cmp_q[0]}, or 0 if the op is reserved; set rsp_err = reserved flag; rsp_rd = latched tag; rsp_valid = 1; go to RESP.
- Latency: rsp_valid rises LATENCY+1 edges after the accept edge (2 edges for the default).
- cmp_* outputs hold stable from accept until the next accept; they never change during WAIT.
- RESP:
  - rsp_valid and all rsp_* hold stable while rsp_ready = 0.
  - rsp_ready = 1 without accept: rsp_valid goes to 0 and state goes to IDLE. rsp_data/rsp_rd keep their last values.
  - rsp_ready = 1 with a same-cycle accept (back-to-back): rsp_valid goes to 0, the new request is loaded, state goes to WAIT. No bubble on the request side.
- req_* are ignored when req_ready = 0; the requester must hold them.
- rstn low in any state: the in-flight request is dropped silently and no response is produced.
- busy is combinational from state.

Optional Feature:
- Macro: FPU_CMP_NAN_EN.
- Defined:
  - on accept, flag NaN if either operand has exponent 0xFF and mantissa != 0;
  - at capture, a set flag forces rsp_data = 0 for lt/le/eq (IEEE unordered) and sets rsp_invalid = 1;
  - the reserved-op rule still applies, and rsp_err is independent of this flag.
- Undefined: no NaN logic; rsp_invalid is tied to 0; rsp_data comes straight from cmp_q[0].
- Port list is identical in both builds.

Test Plan:
- LATENCY=1; op=00, a=0x3F800000 (1.0), b=0x40000000 (2.0), rd=5 -> rsp_valid exactly 2 edges after accept; rsp_data=1, rsp_rd=5, rsp_err=0.
- op=01, a=b=0x40490FDB -> rsp_data=1. Then op=10, a=0x3F800000, b=0x40000000 -> rsp_data=0; cmp_is_eq=1 and cmp_is_le=0 throughout WAIT.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable and req_ready=0. Raise rsp_ready with req_valid=1 (op=00, a=2.0, b=1.0, rd=9) -> same-edge handoff; next rsp_data=0, rsp_rd=9 after LATENCY+1 edges.
- op=11, any operands, rd=3 -> rsp_data=0, rsp_err=1, rsp_rd=3, same latency as legal ops.
- Assert rstn low for one cycle while in WAIT -> all outputs at reset values; no rsp_valid after release; req_ready=1 and busy=0.
- Built with FPU_CMP_NAN_EN: op=01, a=0x7FC00000, b=0x3F800000 -> rsp_data=0, rsp_invalid=1. Same stimulus without the macro -> rsp_invalid=0.
